// File: rtl/pipe_mem_arb.sv
// pipe_mem_arb: single-port memory arbiter between instruction fetch and
// load/store. One transaction outstanding at a time. LSU wins contention,
// except that a saturating starvation counter forces an IFU grant after
// STARVE_LIMIT consecutive contested LSU grants. A flush discards an
// in-flight fetch response, but never withdraws the bus request.
module pipe_mem_arb #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic                if_req_valid_i,
   output logic                if_req_ready_o,
   input  logic [ADDR_W-1:0]   if_req_addr_i,
   output logic                if_rsp_valid_o,
   output logic [DATA_W-1:0]   if_rsp_data_o,
   input  logic                lsu_req_valid_i,
   output logic                lsu_req_ready_o,
   input  logic [ADDR_W-1:0]   lsu_req_addr_i,
   input  logic                lsu_req_we_i,
   input  logic [DATA_W-1:0]   lsu_req_wdata_i,
   input  logic [DATA_W/8-1:0] lsu_req_wstrb_i,
   output logic                lsu_rsp_valid_o,
   output logic [DATA_W-1:0]   lsu_rsp_data_o,
   output logic                mem_req_valid_o,
   input  logic                mem_req_ready_i,
   output logic [ADDR_W-1:0]   mem_req_addr_o,
   output logic                mem_req_we_o,
   output logic [DATA_W-1:0]   mem_req_wdata_o,
   output logic [DATA_W/8-1:0] mem_req_wstrb_o,
   input  logic                mem_rsp_valid_i,
   input  logic [DATA_W-1:0]   mem_rsp_data_i
);

   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;
   typedef enum logic {OWN_LSU, OWN_IF} owner_t;

   state_t            state;
   owner_t            owner;
   logic              drop;
   logic [CNT_W-1:0]  starve_cnt;
   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic              req_we;
   logic [DATA_W-1:0] req_wdata;
   logic [STRB_W-1:0] req_wstrb;

   logic grant_if;
   logic grant_lsu;
   logic starved;
   logic rsp_hit;
   logic kill_fetch;

   // Arbitration in IDLE; the reset term keeps both readies low while held in reset
   always_comb begin
      starved   = (starve_cnt == CNT_MAX);
      grant_if  = 1'b0;
      grant_lsu = 1'b0;
      if (state == ST_IDLE && rst_ni) begin
         if (if_req_valid_i && !flush_i && (!lsu_req_valid_i || starved)) begin
            grant_if = 1'b1;
         end else if (lsu_req_valid_i) begin
            grant_lsu = 1'b1;
         end
      end
   end

   // Response routing: a fetch response is swallowed if a flush was seen at any point since its grant
   always_comb begin
      rsp_hit         = (state == ST_WAIT) && mem_rsp_valid_i;
      kill_fetch      = drop || flush_i;
      if_rsp_valid_o  = rsp_hit && (owner == OWN_IF) && !kill_fetch;
      lsu_rsp_valid_o = rsp_hit && (owner == OWN_LSU);
      if_rsp_data_o   = if_rsp_valid_o  ? mem_rsp_data_i : '0;
      lsu_rsp_data_o  = lsu_rsp_valid_o ? mem_rsp_data_i : '0;
   end

   assign if_req_ready_o  = grant_if;
   assign lsu_req_ready_o = grant_lsu;
   assign mem_req_valid_o = req_valid;
   assign mem_req_addr_o  = req_addr;
   assign mem_req_we_o    = req_we;
   assign mem_req_wdata_o = req_wdata;
   assign mem_req_wstrb_o = req_wstrb;

   // Transaction FSM: latch the winner, hold the bus request until accepted, wait for the response
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= ST_IDLE;
         owner     <= OWN_LSU;
         drop      <= 1'b0;
         req_valid <= 1'b0;
         req_addr  <= '0;
         req_we    <= 1'b0;
         req_wdata <= '0;
         req_wstrb <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_if || grant_lsu) begin
                  state     <= ST_REQ;
                  owner     <= grant_if ? OWN_IF : OWN_LSU;
                  drop      <= 1'b0;
                  req_valid <= 1'b1;
                  req_addr  <= grant_if ? if_req_addr_i : lsu_req_addr_i;
                  req_we    <= grant_lsu && lsu_req_we_i;
                  req_wdata <= grant_lsu ? lsu_req_wdata_i : '0;
                  req_wstrb <= grant_lsu ? lsu_req_wstrb_i : '0;
               end
            end
            ST_REQ: begin
               if (flush_i && owner == OWN_IF) begin
                  drop <= 1'b1;
               end
               if (mem_req_ready_i) begin
                  state     <= ST_WAIT;
                  req_valid <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (flush_i && owner == OWN_IF) begin
                  drop <= 1'b1;
               end
               if (mem_rsp_valid_i) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               req_valid <= 1'b0;
            end
         endcase
      end
   end

   // Starvation counter: counts LSU grants that beat a waiting IFU, cleared whenever the IFU wins
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         starve_cnt <= '0;
      end else if (grant_if) begin
         starve_cnt <= '0;
      end else if (grant_lsu && if_req_valid_i && !starved) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_mem_arb.sv
// tb_pipe_mem_arb: directed bench for pipe_mem_arb. A memory model answers
// bus requests with data queued by the stimulus; the stimulus also queues
// the expected response, which a separate monitor pops and compares
// whenever either response pulse appears.
module tb_pipe_mem_arb;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        flush_i;
   logic        if_req_valid_i;
   logic        if_req_ready_o;
   logic [31:0] if_req_addr_i;
   logic        if_rsp_valid_o;
   logic [31:0] if_rsp_data_o;
   logic        lsu_req_valid_i;
   logic        lsu_req_ready_o;
   logic [31:0] lsu_req_addr_i;
   logic        lsu_req_we_i;
   logic [31:0] lsu_req_wdata_i;
   logic [3:0]  lsu_req_wstrb_i;
   logic        lsu_rsp_valid_o;
   logic [31:0] lsu_rsp_data_o;
   logic        mem_req_valid_o;
   logic        mem_req_ready_i;
   logic [31:0] mem_req_addr_o;
   logic        mem_req_we_o;
   logic [31:0] mem_req_wdata_o;
   logic [3:0]  mem_req_wstrb_o;
   logic        mem_rsp_valid_i;
   logic [31:0] mem_rsp_data_i;

   logic        model_rsp_valid;
   logic [31:0] model_rsp_data;
   logic        stray_rsp_valid;
   logic [31:0] stray_rsp_data;

   assign mem_rsp_valid_i = model_rsp_valid | stray_rsp_valid;
   assign mem_rsp_data_i  = stray_rsp_valid ? stray_rsp_data : model_rsp_data;

   typedef struct {
      bit          is_lsu;
      bit          check_data;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem_data_q[$];
   int          stall_cfg;
   int          rsp_delay_cfg;
   int          errors;
   int          checks;

   pipe_mem_arb #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .if_req_valid_i(if_req_valid_i), .if_req_ready_o(if_req_ready_o),
      .if_req_addr_i(if_req_addr_i), .if_rsp_valid_o(if_rsp_valid_o),
      .if_rsp_data_o(if_rsp_data_o),
      .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
      .lsu_req_addr_i(lsu_req_addr_i), .lsu_req_we_i(lsu_req_we_i),
      .lsu_req_wdata_i(lsu_req_wdata_i), .lsu_req_wstrb_i(lsu_req_wstrb_i),
      .lsu_rsp_valid_o(lsu_rsp_valid_o), .lsu_rsp_data_o(lsu_rsp_data_o),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
      .mem_req_addr_o(mem_req_addr_o), .mem_req_we_o(mem_req_we_o),
      .mem_req_wdata_o(mem_req_wdata_o), .mem_req_wstrb_o(mem_req_wstrb_o),
      .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic ifv, input logic [31:0] ifa, input logic lsuv,
                                input logic [31:0] lsua, input logic we, input logic [31:0] wd,
                                input logic [3:0] ws, input logic fl);
      if_req_valid_i  = ifv;
      if_req_addr_i   = ifa;
      lsu_req_valid_i = lsuv;
      lsu_req_addr_i  = lsua;
      lsu_req_we_i    = we;
      lsu_req_wdata_i = wd;
      lsu_req_wstrb_i = ws;
      flush_i         = fl;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic expectRsp(input bit is_lsu, input bit chk, input logic [31:0] d);
      exp_t e;
      e.is_lsu     = is_lsu;
      e.check_data = chk;
      e.data       = d;
      exp_q.push_back(e);
   endtask

   // Memory model: ready after stall_cfg wait cycles, response rsp_delay_cfg cycles after handshake
   initial begin : mem_model
      bit hs_seen;
      int stall_count;
      int rsp_wait;
      mem_req_ready_i = 1'b0;
      model_rsp_valid = 1'b0;
      model_rsp_data  = '0;
      stall_count     = 0;
      rsp_wait        = -1;
      forever begin
         @(negedge clk_i);
         hs_seen = mem_req_valid_o && mem_req_ready_i;
         @(posedge clk_i);
         #1;
         model_rsp_valid = 1'b0;
         mem_req_ready_i = 1'b0;
         if (!rst_ni) begin
            rsp_wait    = -1;
            stall_count = 0;
            hs_seen     = 1'b0;
         end
         if (hs_seen) begin
            rsp_wait    = rsp_delay_cfg;
            stall_count = 0;
         end
         if (rsp_wait == 0) begin
            model_rsp_valid = 1'b1;
            model_rsp_data  = (mem_data_q.size() > 0) ? mem_data_q.pop_front() : 32'h0;
            rsp_wait        = -1;
         end else if (rsp_wait > 0) begin
            rsp_wait--;
         end
         if (!hs_seen && mem_req_valid_o && rsp_wait < 0) begin
            if (stall_count >= stall_cfg) mem_req_ready_i = 1'b1;
            else stall_count++;
         end
      end
   end

   // Scoreboard monitor: every response pulse must match the oldest queued expectation
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (if_rsp_valid_o || lsu_rsp_valid_o) begin
            checkOutput("rsp_single", 32'(if_rsp_valid_o & lsu_rsp_valid_o), 32'h0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_rsp: if=%0b lsu=%0b, expected no pulse at %0t",
                        if_rsp_valid_o, lsu_rsp_valid_o, $time);
            end else begin
               e = exp_q.pop_front();
               checkOutput("rsp_owner_lsu", 32'(lsu_rsp_valid_o), 32'(e.is_lsu));
               if (e.check_data)
                  checkOutput("rsp_data", e.is_lsu ? lsu_rsp_data_o : if_rsp_data_o, e.data);
            end
         end
      end
   end

   // Watchdog so the run always terminates
   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] timeout");
   end

   // Directed stimulus
   initial begin : stimulus
      errors          = 0;
      checks          = 0;
      stall_cfg       = 0;
      rsp_delay_cfg   = 0;
      stray_rsp_valid = 1'b0;
      stray_rsp_data  = '0;
      rst_ni          = 1'b0;
      applyStimulus(1'b1, 32'h8000_0000, 1'b1, 32'h8000_1000, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0);

      // Reset state with both requesters asserting
      @(negedge clk_i);
      @(negedge clk_i);
      checkOutput("rst_if_ready", 32'(if_req_ready_o), 32'h0);
      checkOutput("rst_lsu_ready", 32'(lsu_req_ready_o), 32'h0);
      checkOutput("rst_mem_valid", 32'(mem_req_valid_o), 32'h0);
      checkOutput("rst_mem_addr", mem_req_addr_o, 32'h0);
      tick();
      rst_ni = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0);

      // IFU-only fetch
      tick();
      applyStimulus(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0);
      mem_data_q.push_back(32'h0000_0513);
      expectRsp(1'b0, 1'b1, 32'h0000_0513);
      @(negedge clk_i);
      checkOutput("f1_if_ready", 32'(if_req_ready_o), 32'h1);
      checkOutput("f1_lsu_ready", 32'(lsu_req_ready_o), 32'h0);
      tick();
      if_req_valid_i = 1'b0;
      @(negedge clk_i);
      checkOutput("f1_mem_valid", 32'(mem_req_valid_o), 32'h1);
      checkOutput("f1_mem_addr", mem_req_addr_o, 32'h8000_0000);
      checkOutput("f1_mem_we", 32'(mem_req_we_o), 32'h0);
      checkOutput("f1_mem_wstrb", 32'(mem_req_wstrb_o), 32'h0);
      tick();
      @(negedge clk_i);
      checkOutput("f1_if_rsp_valid", 32'(if_rsp_valid_o), 32'h1);
      checkOutput("f1_lsu_rsp_valid", 32'(lsu_rsp_valid_o), 32'h0);
      tick();

      // LSU store contending with IFU
      applyStimulus(1'b1, 32'h8000_0004, 1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0);
      mem_data_q.push_back(32'h0);
      expectRsp(1'b1, 1'b0, 32'h0);
      mem_data_q.push_back(32'hAAAA_0004);
      expectRsp(1'b0, 1'b1, 32'hAAAA_0004);
      @(negedge clk_i);
      checkOutput("st_lsu_ready", 32'(lsu_req_ready_o), 32'h1);
      checkOutput("st_if_ready", 32'(if_req_ready_o), 32'h0);
      tick();
      lsu_req_valid_i = 1'b0;
      @(negedge clk_i);
      checkOutput("st_mem_we", 32'(mem_req_we_o), 32'h1);
      checkOutput("st_mem_addr", mem_req_addr_o, 32'h8000_1000);
      checkOutput("st_mem_wdata", mem_req_wdata_o, 32'hDEAD_BEEF);
      checkOutput("st_mem_wstrb", 32'(mem_req_wstrb_o), 32'hF);
      checkOutput("st_if_ready_busy", 32'(if_req_ready_o), 32'h0);
      checkOutput("st_starve_cnt", 32'(dut.starve_cnt), 32'h1);
      tick();
      tick();
      @(negedge clk_i);
      checkOutput("st_if_grant_next", 32'(if_req_ready_o), 32'h1);
      tick();
      if_req_valid_i = 1'b0;
      tick();
      tick();

      // Starvation: both held valid, expect L L L L I L
      for (int k = 0; k < 6; k++) begin
         mem_data_q.push_back(32'h1000_0000 + 32'(k));
         expectRsp(k != 4, 1'b1, 32'h1000_0000 + 32'(k));
      end
      applyStimulus(1'b1, 32'h8000_0008, 1'b1, 32'h8000_2000, 1'b0, 32'h0, 4'h0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_i);
         checkOutput($sformatf("sv_lsu_ready_%0d", k), 32'(lsu_req_ready_o), (k != 4) ? 32'h1 : 32'h0);
         checkOutput($sformatf("sv_if_ready_%0d", k), 32'(if_req_ready_o), (k == 4) ? 32'h1 : 32'h0);
         tick();
         if (k == 5) begin
            if_req_valid_i  = 1'b0;
            lsu_req_valid_i = 1'b0;
         end
         @(negedge clk_i);
         if (k == 3) checkOutput("sv_starve_sat", 32'(dut.starve_cnt), 32'h4);
         if (k == 4) checkOutput("sv_starve_clr", 32'(dut.starve_cnt), 32'h0);
         if (k == 5) checkOutput("sv_starve_one", 32'(dut.starve_cnt), 32'h1);
         tick();
         tick();
      end

      // Flush during fetch while the bus is stalled
      stall_cfg = 3;
      applyStimulus(1'b1, 32'h8000_0010, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0);
      mem_data_q.push_back(32'h1234_5678);
      @(negedge clk_i);
      checkOutput("fl_if_ready", 32'(if_req_ready_o), 32'h1);
      tick();
      if_req_valid_i = 1'b0;
      flush_i        = 1'b1;
      @(negedge clk_i);
      checkOutput("fl_mem_valid_0", 32'(mem_req_valid_o), 32'h1);
      tick();
      flush_i = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk_i);
         checkOutput($sformatf("fl_mem_valid_%0d", c), 32'(mem_req_valid_o), 32'h1);
         checkOutput($sformatf("fl_mem_addr_%0d", c), mem_req_addr_o, 32'h8000_0010);
         tick();
      end
      @(negedge clk_i);
      checkOutput("fl_no_if_rsp", 32'(if_rsp_valid_o), 32'h0);
      stall_cfg = 0;
      tick();
      applyStimulus(1'b1, 32'h8000_0014, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0);
      mem_data_q.push_back(32'h0000_0093);
      expectRsp(1'b0, 1'b1, 32'h0000_0093);
      @(negedge clk_i);
      checkOutput("fl_idle_regrant", 32'(if_req_ready_o), 32'h1);
      tick();
      if_req_valid_i = 1'b0;
      tick();
      tick();

      // Flush coinciding with the fetch response
      applyStimulus(1'b1, 32'h8000_0018, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0);
      mem_data_q.push_back(32'h0BAD_0018);
      tick();
      if_req_valid_i = 1'b0;
      tick();
      flush_i = 1'b1;
      @(negedge clk_i);
      checkOutput("flr_no_if_rsp", 32'(if_rsp_valid_o), 32'h0);
      tick();
      flush_i = 1'b0;

      // Flush with IFU-only request in IDLE: no grant until flush drops
      applyStimulus(1'b1, 32'h8000_001C, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1);
      @(negedge clk_i);
      checkOutput("fi_no_grant", 32'(if_req_ready_o), 32'h0);
      tick();
      flush_i = 1'b0;
      mem_data_q.push_back(32'h0000_001C);
      expectRsp(1'b0, 1'b1, 32'h0000_001C);
      @(negedge clk_i);
      checkOutput("fi_grant_after", 32'(if_req_ready_o), 32'h1);
      tick();
      if_req_valid_i = 1'b0;
      tick();
      tick();

      // Flush does not touch an LSU load
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_3000, 1'b0, 32'h0, 4'h0, 1'b0);
      mem_data_q.push_back(32'hCAFE_F00D);
      expectRsp(1'b1, 1'b1, 32'hCAFE_F00D);
      @(negedge clk_i);
      checkOutput("fls_lsu_ready", 32'(lsu_req_ready_o), 32'h1);
      tick();
      lsu_req_valid_i = 1'b0;
      flush_i         = 1'b1;
      tick();
      @(negedge clk_i);
      checkOutput("fls_lsu_rsp_valid", 32'(lsu_rsp_valid_o), 32'h1);
      checkOutput("fls_lsu_rsp_data", lsu_rsp_data_o, 32'hCAFE_F00D);
      tick();
      flush_i = 1'b0;

      // Reset while waiting for a slow response, then a stray response
      rsp_delay_cfg = 3;
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_4000, 1'b1, 32'h1111_2222, 4'h3, 1'b0);
      mem_data_q.push_back(32'hBAD0_BAD0);
      @(negedge clk_i);
      checkOutput("rw_lsu_ready", 32'(lsu_req_ready_o), 32'h1);
      tick();
      lsu_req_valid_i = 1'b0;
      tick();
      tick();
      rst_ni = 1'b0;
      applyStimulus(1'b1, 32'h8000_0020, 1'b1, 32'h8000_5000, 1'b1, 32'h3333_4444, 4'hF, 1'b0);
      @(negedge clk_i);
      checkOutput("rw_mem_valid", 32'(mem_req_valid_o), 32'h0);
      checkOutput("rw_mem_addr", mem_req_addr_o, 32'h0);
      checkOutput("rw_mem_we", 32'(mem_req_we_o), 32'h0);
      checkOutput("rw_mem_wdata", mem_req_wdata_o, 32'h0);
      checkOutput("rw_mem_wstrb", 32'(mem_req_wstrb_o), 32'h0);
      checkOutput("rw_if_ready", 32'(if_req_ready_o), 32'h0);
      checkOutput("rw_lsu_ready", 32'(lsu_req_ready_o), 32'h0);
      tick();
      tick();
      rst_ni = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0);
      mem_data_q.delete();
      rsp_delay_cfg = 0;
      tick();
      stray_rsp_valid = 1'b1;
      stray_rsp_data  = 32'h5555_AAAA;
      @(negedge clk_i);
      checkOutput("stray_if_rsp", 32'(if_rsp_valid_o), 32'h0);
      checkOutput("stray_lsu_rsp", 32'(lsu_rsp_valid_o), 32'h0);
      tick();
      stray_rsp_valid = 1'b0;
      applyStimulus(1'b1, 32'h8000_0020, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0);
      mem_data_q.push_back(32'h0010_0073);
      expectRsp(1'b0, 1'b1, 32'h0010_0073);
      @(negedge clk_i);
      checkOutput("post_rst_if_ready", 32'(if_req_ready_o), 32'h1);
      tick();
      if_req_valid_i = 1'b0;
      @(negedge clk_i);
      checkOutput("post_rst_mem_addr", mem_req_addr_o, 32'h8000_0020);
      tick();
      tick();
      tick();
      tick();

      checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
